// File: rtl/rrf_alloc_ptr_pkg.sv
// Shared constants and width helpers for the rename-register tag allocator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rrf_alloc_ptr_pkg;

    // Number of RRF/ROB entries (power of two) and the tag width.
    localparam int RRF_NUM = 64;
    localparam int RRF_SEL = 6;

    // Free-count width: it must hold 0..RRF_NUM inclusive, one bit wider than a tag.
    function automatic int rrf_free_w(input int sel);
        return sel + 1;
    endfunction

    // Arithmetic width for the next free count: one more bit than the count,
    // so a negative result shows up in the MSB and a result above RRF_NUM stays visible.
    function automatic int rrf_calc_w(input int sel);
        return sel + 2;
    endfunction

    // Request encoding: 3 is treated as 2 (two dispatch slots per cycle).
    function automatic logic [1:0] rrf_clip_req(input logic [1:0] req);
        return (req == 2'd3) ? 2'd2 : req;
    endfunction

endpackage

// File: rtl/rrf_alloc_ptr.sv
// RRF/ROB tag allocator: hands out up to two tags per cycle and reclaims them on ROB commit.
// Latency: tags on dp1/dp2_addr_o are usable in the request cycle; pointer, count and bitmap update on the next edge.
// Backpressure: a request is refused whole (no partial grant) when stall_i/prmiss_i is high or too few tags are free.
module rrf_alloc_ptr
    import rrf_alloc_ptr_pkg::*;
#(
    parameter int RRF_NUM_P = RRF_NUM,
    parameter int RRF_SEL_P = RRF_SEL
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [1:0]             req_num_i,
    input  logic                   stall_i,
    input  logic [1:0]             comnum_i,
    input  logic [RRF_SEL_P-1:0]   commit_ptr_i,
    input  logic                   prmiss_i,
    output logic                   allocatable_o,
    output logic                   alloc_o,
    output logic [RRF_SEL_P-1:0]   dp1_addr_o,
    output logic [RRF_SEL_P-1:0]   dp2_addr_o,
    output logic [RRF_SEL_P-1:0]   dispatch_ptr_o,
    output logic [RRF_SEL_P:0]     rrf_freenum_o,
    output logic [RRF_NUM_P-1:0]   rrfvalid_o,
    output logic                   err_o
);

    localparam int FREE_W = rrf_free_w(RRF_SEL_P);
    localparam int CALC_W = rrf_calc_w(RRF_SEL_P);

    // Architectural state
    logic [RRF_SEL_P-1:0] ptr_q,   ptr_d;
    logic [FREE_W-1:0]    free_q,  free_d;
    logic [RRF_NUM_P-1:0] valid_q, valid_d;
    logic                 err_q,   err_d;

    // Decode
    logic [1:0]           req_eff;
    logic [1:0]           alloc_n;
    logic [RRF_SEL_P-1:0] ptr_p1;
    logic [RRF_SEL_P-1:0] commit_p1;
    logic [FREE_W-1:0]    valid_cnt;
    logic [CALC_W-1:0]    free_calc;
    logic                 free_neg;
    logic                 free_over;
    logic                 commit_err;
    logic [RRF_NUM_P-1:0] set_mask;
    logic [RRF_NUM_P-1:0] clr_mask;

    assign req_eff   = rrf_clip_req(req_num_i);
    assign ptr_p1    = ptr_q + RRF_SEL_P'(1);
    assign commit_p1 = commit_ptr_i + RRF_SEL_P'(1);

    // The count compared here is the registered one, so commits landing this
    // cycle cannot unblock a request until the following cycle.
    assign allocatable_o = (free_q >= FREE_W'(req_eff));
    assign alloc_o       = (req_num_i != 2'd0) & allocatable_o & ~stall_i & ~prmiss_i;
    assign alloc_n       = alloc_o ? req_eff : 2'd0;

    assign dp1_addr_o     = ptr_q;
    assign dp2_addr_o     = ptr_p1;
    assign dispatch_ptr_o = ptr_q;
    assign rrf_freenum_o  = free_q;
    assign rrfvalid_o     = valid_q;
    assign err_o          = err_q;

    // Count of tags currently allocated and not yet committed.
    always_comb begin
        valid_cnt = '0;
        for (int i = 0; i < RRF_NUM_P; i++) begin
            valid_cnt = valid_cnt + FREE_W'(valid_q[i]);
        end
    end

    // Next free count in a wider field: MSB set means it went negative,
    // anything above RRF_NUM means more tags came back than were out.
    always_comb begin
        free_calc  = CALC_W'(free_q) + CALC_W'(comnum_i) - CALC_W'(alloc_n);
        free_neg   = free_calc[CALC_W-1];
        free_over  = ~free_neg & (free_calc > CALC_W'(RRF_NUM_P));
        commit_err = (FREE_W'(comnum_i) > valid_cnt);
    end

    // Bitmap set/clear masks for this cycle's allocation and commit.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (alloc_n != 2'd0) set_mask[ptr_q]        = 1'b1;
        if (alloc_n == 2'd2) set_mask[ptr_p1]       = 1'b1;
        if (comnum_i != 2'd0) clr_mask[commit_ptr_i] = 1'b1;
        if (comnum_i >= 2'd2) clr_mask[commit_p1]    = 1'b1;
    end

    // Next-state selection: mispredict rebuilds from the commit point, otherwise
    // apply allocation and commit together, with sets overriding clears.
    always_comb begin
        ptr_d   = ptr_q;
        free_d  = free_q;
        valid_d = valid_q;
        err_d   = err_q | commit_err;
        if (prmiss_i) begin
            ptr_d   = commit_ptr_i + RRF_SEL_P'(comnum_i);
            free_d  = FREE_W'(RRF_NUM_P);
            valid_d = '0;
        end else begin
            ptr_d   = ptr_q + RRF_SEL_P'(alloc_n);
            valid_d = (valid_q & ~clr_mask) | set_mask;
            if (free_neg) begin
                free_d = '0;
                err_d  = 1'b1;
            end else if (free_over) begin
                free_d = FREE_W'(RRF_NUM_P);
                err_d  = 1'b1;
            end else begin
                free_d = free_calc[FREE_W-1:0];
            end
        end
    end

    // Pointer, free count, bitmap and sticky error register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ptr_q   <= '0;
            free_q  <= FREE_W'(RRF_NUM_P);
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            free_q  <= free_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_rrf_alloc_ptr.sv
// Bench for the RRF tag allocator: directed scenarios plus randomized legal traffic
// checked against a counting model of the tag pool.
// Inputs change 1-2 time units after the rising edge; outputs are sampled away from it.
module tb_rrf_alloc_ptr;

    localparam int N   = 64;
    localparam int SEL = 6;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic [1:0]     req_num_i;
    logic           stall_i;
    logic [1:0]     comnum_i;
    logic [SEL-1:0] commit_ptr_i;
    logic           prmiss_i;
    logic           allocatable_o;
    logic           alloc_o;
    logic [SEL-1:0] dp1_addr_o;
    logic [SEL-1:0] dp2_addr_o;
    logic [SEL-1:0] dispatch_ptr_o;
    logic [SEL:0]   rrf_freenum_o;
    logic [N-1:0]   rrfvalid_o;
    logic           err_o;

    always #5 clk_i = ~clk_i;

    rrf_alloc_ptr dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req_num_i      (req_num_i),
        .stall_i        (stall_i),
        .comnum_i       (comnum_i),
        .commit_ptr_i   (commit_ptr_i),
        .prmiss_i       (prmiss_i),
        .allocatable_o  (allocatable_o),
        .alloc_o        (alloc_o),
        .dp1_addr_o     (dp1_addr_o),
        .dp2_addr_o     (dp2_addr_o),
        .dispatch_ptr_o (dispatch_ptr_o),
        .rrf_freenum_o  (rrf_freenum_o),
        .rrfvalid_o     (rrfvalid_o),
        .err_o          (err_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference pool: next tag to hand out, free count, which tags are out, sticky error.
    int m_ptr;
    int m_free;
    bit m_valid [N];
    bit m_err;

    function automatic int eff_req(input int r);
        return (r > 2) ? 2 : r;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_valid[i];
        return c;
    endfunction

    function automatic logic [N-1:0] m_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic bit m_allocatable();
        return m_free >= eff_req(int'(req_num_i));
    endfunction

    function automatic bit m_alloc();
        return (req_num_i != 0) && m_allocatable() && !stall_i && !prmiss_i;
    endfunction

    task automatic m_reset();
        m_ptr  = 0;
        m_free = N;
        m_err  = 0;
        for (int i = 0; i < N; i++) m_valid[i] = 0;
    endtask

    // Advance the reference by one clock using the inputs currently applied.
    task automatic m_step();
        int n, cn, cp, f;
        n  = m_alloc() ? eff_req(int'(req_num_i)) : 0;
        cn = int'(comnum_i);
        cp = int'(commit_ptr_i);
        if (cn > m_count()) m_err = 1;
        if (prmiss_i) begin
            m_ptr  = (cp + cn) % N;
            m_free = N;
            for (int i = 0; i < N; i++) m_valid[i] = 0;
        end else begin
            f = m_free - n + cn;
            if (f > N) begin f = N; m_err = 1; end
            if (f < 0) begin f = 0; m_err = 1; end
            if (cn >= 1) m_valid[cp] = 0;
            if (cn >= 2) m_valid[(cp + 1) % N] = 0;
            if (n >= 1) m_valid[m_ptr] = 1;
            if (n >= 2) m_valid[(m_ptr + 1) % N] = 1;
            m_ptr  = (m_ptr + n) % N;
            m_free = f;
        end
    endtask

    task automatic drive(input int req, input bit st, input int cn, input int cp, input bit pm);
        req_num_i    = 2'(req);
        stall_i      = st;
        comnum_i     = 2'(cn);
        commit_ptr_i = SEL'(cp);
        prmiss_i     = pm;
        #1;
    endtask

    task automatic tick();
        m_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        drive(0, 0, 0, 0, 0);
        m_reset();
        @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;
    endtask

    // Hand out k tags from the current pointer, two at a time.
    task automatic alloc_tags(input int k);
        int left = k;
        while (left > 0) begin
            drive((left >= 2) ? 2 : 1, 0, 0, 0, 0);
            tick();
            left -= (left >= 2) ? 2 : 1;
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        drive(2, 0, 0, 0, 0);
        m_reset();
        #3;
        total++; if (dispatch_ptr_o !== 6'd0) begin bad++; $display("FAIL reset_ptr got=%0d want=0", dispatch_ptr_o); end
        total++; if (rrf_freenum_o !== 7'd64) begin bad++; $display("FAIL reset_free got=%0d want=64", rrf_freenum_o); end
        total++; if (rrfvalid_o !== '0) begin bad++; $display("FAIL reset_valid got=%h want=0", rrfvalid_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_o); end
        @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;
        total++; if (allocatable_o !== 1'b1) begin bad++; $display("FAIL reset_allocatable got=%b want=1", allocatable_o); end
    endtask

    task automatic test_basic_alloc();
        do_reset();
        drive(2, 0, 0, 0, 0);
        total++; if (dp1_addr_o !== 6'd0) begin bad++; $display("FAIL basic_dp1 got=%0d want=0", dp1_addr_o); end
        total++; if (dp2_addr_o !== 6'd1) begin bad++; $display("FAIL basic_dp2 got=%0d want=1", dp2_addr_o); end
        total++; if (alloc_o !== 1'b1) begin bad++; $display("FAIL basic_alloc got=%b want=1", alloc_o); end
        tick();
        total++; if (dispatch_ptr_o !== 6'd2) begin bad++; $display("FAIL basic_ptr got=%0d want=2", dispatch_ptr_o); end
        total++; if (rrf_freenum_o !== 7'd62) begin bad++; $display("FAIL basic_free got=%0d want=62", rrf_freenum_o); end
        total++; if (rrfvalid_o !== m_vec() || rrfvalid_o[1:0] !== 2'b11) begin bad++; $display("FAIL basic_valid got=%h want=%h", rrfvalid_o, m_vec()); end
        // stall blocks allocation
        drive(1, 1, 0, 0, 0);
        total++; if (alloc_o !== 1'b0) begin bad++; $display("FAIL stall_alloc got=%b want=0", alloc_o); end
        tick();
        total++; if (dispatch_ptr_o !== 6'd2) begin bad++; $display("FAIL stall_ptr got=%0d want=2", dispatch_ptr_o); end
    endtask

    task automatic test_full();
        do_reset();
        alloc_tags(63);
        drive(2, 0, 0, 0, 0);
        total++; if (allocatable_o !== 1'b0) begin bad++; $display("FAIL full_allocatable got=%b want=0", allocatable_o); end
        total++; if (alloc_o !== 1'b0) begin bad++; $display("FAIL full_alloc got=%b want=0", alloc_o); end
        tick();
        total++; if (dispatch_ptr_o !== 6'd63 || rrf_freenum_o !== 7'd1) begin bad++; $display("FAIL full_hold got ptr=%0d free=%0d want ptr=63 free=1", dispatch_ptr_o, rrf_freenum_o); end
        drive(1, 0, 0, 0, 0);
        total++; if (alloc_o !== 1'b1 || dp1_addr_o !== 6'd63) begin bad++; $display("FAIL full_req1 got alloc=%b dp1=%0d want alloc=1 dp1=63", alloc_o, dp1_addr_o); end
        tick();
        total++; if (rrf_freenum_o !== 7'd0 || dispatch_ptr_o !== 6'd0 || rrfvalid_o !== {N{1'b1}}) begin bad++; $display("FAIL full_last got free=%0d ptr=%0d valid=%h want free=0 ptr=0 all ones", rrf_freenum_o, dispatch_ptr_o, rrfvalid_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        alloc_tags(63);
        // a commit in the same cycle does not unblock a request
        drive(2, 0, 1, 0, 0);
        total++; if (allocatable_o !== 1'b0) begin bad++; $display("FAIL wrap_same_cycle got=%b want=0", allocatable_o); end
        tick();
        total++; if (rrf_freenum_o !== 7'd2) begin bad++; $display("FAIL wrap_free2 got=%0d want=2", rrf_freenum_o); end
        drive(2, 0, 0, 0, 0);
        total++; if (dp1_addr_o !== 6'd63 || dp2_addr_o !== 6'd0 || alloc_o !== 1'b1) begin bad++; $display("FAIL wrap_addr got dp1=%0d dp2=%0d alloc=%b want 63 0 1", dp1_addr_o, dp2_addr_o, alloc_o); end
        tick();
        total++; if (dispatch_ptr_o !== 6'd1 || rrf_freenum_o !== 7'd0) begin bad++; $display("FAIL wrap_next got ptr=%0d free=%0d want ptr=1 free=0", dispatch_ptr_o, rrf_freenum_o); end
    endtask

    task automatic test_simul();
        do_reset();
        alloc_tags(54);
        drive(2, 0, 2, 0, 0);
        tick();
        total++; if (rrf_freenum_o !== 7'd10) begin bad++; $display("FAIL simul_free got=%0d want=10", rrf_freenum_o); end
        total++; if (rrfvalid_o[1:0] !== 2'b00 || rrfvalid_o[55:54] !== 2'b11 || rrfvalid_o !== m_vec()) begin bad++; $display("FAIL simul_valid got=%h want=%h", rrfvalid_o, m_vec()); end
    endtask

    task automatic test_prmiss();
        // continues from test_simul: tags 2..55 outstanding
        drive(2, 0, 1, 10, 1);
        total++; if (alloc_o !== 1'b0) begin bad++; $display("FAIL prmiss_alloc got=%b want=0", alloc_o); end
        tick();
        total++; if (dispatch_ptr_o !== 6'd11 || rrf_freenum_o !== 7'd64 || rrfvalid_o !== '0) begin bad++; $display("FAIL prmiss_state got ptr=%0d free=%0d valid=%h want 11 64 0", dispatch_ptr_o, rrf_freenum_o, rrfvalid_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL prmiss_err got=%b want=0", err_o); end
    endtask

    task automatic test_err();
        do_reset();
        alloc_tags(1);
        drive(0, 0, 2, 0, 0);
        tick();
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", err_o); end
        total++; if (rrf_freenum_o !== 7'd64) begin bad++; $display("FAIL err_sat got=%0d want=64", rrf_freenum_o); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);
            tick();
        end
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err_o); end
    endtask

    task automatic test_random();
        int outs, oldest, cn, req;
        bit st, pm;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            outs   = N - m_free;
            oldest = (m_ptr - outs + N) % N;
            cn     = $urandom_range(0, (outs < 2) ? outs : 2);
            req    = $urandom_range(0, 3);
            st     = ($urandom_range(0, 3) == 0);
            pm     = ($urandom_range(0, 47) == 0);
            drive(req, st, cn, oldest, pm);
            total++; if (allocatable_o !== m_allocatable()) begin bad++; $display("FAIL rnd_allocatable c=%0d got=%b want=%b", c, allocatable_o, m_allocatable()); end
            total++; if (alloc_o !== m_alloc()) begin bad++; $display("FAIL rnd_alloc c=%0d got=%b want=%b", c, alloc_o, m_alloc()); end
            total++; if (dp1_addr_o !== SEL'(m_ptr) || dp2_addr_o !== SEL'((m_ptr + 1) % N)) begin bad++; $display("FAIL rnd_dp c=%0d got=%0d/%0d want=%0d", c, dp1_addr_o, dp2_addr_o, m_ptr); end
            tick();
            total++; if (dispatch_ptr_o !== SEL'(m_ptr)) begin bad++; $display("FAIL rnd_ptr c=%0d got=%0d want=%0d", c, dispatch_ptr_o, m_ptr); end
            total++; if (rrf_freenum_o !== 7'(m_free)) begin bad++; $display("FAIL rnd_free c=%0d got=%0d want=%0d", c, rrf_freenum_o, m_free); end
            total++; if (rrfvalid_o !== m_vec()) begin bad++; $display("FAIL rnd_valid c=%0d got=%h want=%h", c, rrfvalid_o, m_vec()); end
            total++; if (err_o !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, err_o, m_err); end
            if (c == 1500) begin
                // asynchronous reset mid-burst, away from any clock edge
                #2;
                reset_i = 1'b0;
                #1;
                total++; if (dispatch_ptr_o !== 6'd0 || rrf_freenum_o !== 7'd64 || rrfvalid_o !== '0 || err_o !== 1'b0) begin bad++; $display("FAIL midreset got ptr=%0d free=%0d valid=%h err=%b want 0 64 0 0", dispatch_ptr_o, rrf_freenum_o, rrfvalid_o, err_o); end
                m_reset();
                @(posedge clk_i);
                #2;
                reset_i = 1'b1;
                #1;
            end
        end
    endtask

    initial begin
        reset_i      = 1'b0;
        req_num_i    = 2'd0;
        stall_i      = 1'b0;
        comnum_i     = 2'd0;
        commit_ptr_i = '0;
        prmiss_i     = 1'b0;
        #2;
        test_reset();
        test_basic_alloc();
        test_full();
        test_wrap();
        test_simul();
        test_prmiss();
        test_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
